// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer and IF/ID register: redirects on taken branches/jumps,
// kills the wrong-path fetch, honours stalls and counts redirects.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             br_taken,
    input  logic             is_jump,
    input  logic [31:0]      ex_target,
    input  logic             stall,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_instr,
    output logic             if_valid,
    output logic             flush,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t      state, state_nxt;
    logic        redirect;
    logic [31:0] pc_p0, pc_nxt;
    logic [31:0] if_pc_nxt, if_instr_nxt;
    logic        if_valid_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign redirect  = ex_valid & (br_taken | is_jump);
    assign flush     = redirect;
    assign imem_addr = pc_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    // BOOT holds everything; RUN applies redirect > stall > sequential advance.
    always_comb begin
        pc_nxt       = pc_p0;
        if_pc_nxt    = if_pc;
        if_instr_nxt = if_instr;
        if_valid_nxt = if_valid;
        if (state == RUN) begin
            if (redirect) begin
                pc_nxt       = {ex_target[31:2], 2'b00};
                if_pc_nxt    = pc_p0;
                if_instr_nxt = NOP_INSTR;
                if_valid_nxt = 1'b0;
            end else if (!stall) begin
                pc_nxt       = pc_p0 + 32'd4;
                if_pc_nxt    = pc_p0;
                if_instr_nxt = imem_rdata;
                if_valid_nxt = 1'b1;
            end
        end
    end

    // IF stage PC and IF/ID boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p0    <= RESET_PC;
            if_pc    <= 32'h0;
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
        end else begin
            pc_p0    <= pc_nxt;
            if_pc    <= if_pc_nxt;
            if_instr <= if_instr_nxt;
            if_valid <= if_valid_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        redirect_cnt <= '0;
        else if (redirect) redirect_cnt <= sat_inc(redirect_cnt);
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed, table-driven bench for fetch_redirect_ctrl (4-bit counter build)
// plus hand-written saturation and asynchronous-reset sequences.
module tb_fetch_redirect_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ex_valid, br_taken, is_jump, stall;
    logic [31:0]      ex_target;
    logic [31:0]      imem_addr, imem_rdata, if_pc, if_instr;
    logic             if_valid, flush;
    logic [CNT_W-1:0] redirect_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_redirect_ctrl #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .br_taken    (br_taken),
        .is_jump     (is_jump),
        .ex_target   (ex_target),
        .stall       (stall),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_valid    (if_valid),
        .flush       (flush),
        .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory stand-in: word is a fixed pattern of its address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata = mem(imem_addr);

    typedef struct {
        logic        ev, bt, ij, st;
        logic [31:0] tgt;
        logic        fl;
        logic [31:0] pc;
        logic        v;
        logic [31:0] ipc, ins;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic ev, bt, ij, st, input logic [31:0] tgt,
                                input logic fl, input logic [31:0] pc, input logic v,
                                input logic [31:0] ipc, ins, input logic [3:0] cnt);
        vec_t r;
        r.ev = ev; r.bt = bt; r.ij = ij; r.st = st; r.tgt = tgt;
        r.fl = fl; r.pc = pc; r.v = v; r.ipc = ipc; r.ins = ins; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ev, bt, ij, st, input logic [31:0] tgt);
        ex_valid = ev; br_taken = bt; is_jump = ij; stall = st; ex_target = tgt;
    endtask

    // Inputs change 1ns after an edge; flush sampled 1ns later, registers 1ns after the next edge.
    task automatic step(input vec_t t, input int i);
        drive(t.ev, t.bt, t.ij, t.st, t.tgt);
        #1;
        chk($sformatf("v%0d.flush", i), {31'b0, flush}, {31'b0, t.fl});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d.imem_addr", i), imem_addr, t.pc);
        chk($sformatf("v%0d.if_valid", i), {31'b0, if_valid}, {31'b0, t.v});
        chk($sformatf("v%0d.if_pc", i), if_pc, t.ipc);
        chk($sformatf("v%0d.if_instr", i), if_instr, t.ins);
        chk($sformatf("v%0d.cnt", i), {28'b0, redirect_cnt}, {28'b0, t.cnt});
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        //             ev bt ij st  target          fl  pc             v  if_pc          if_instr          cnt
        vecs[0]  = mk(1, 1, 0, 1, 32'h0000_0500, 1, 32'h0000_0000, 0, 32'h0000_0000, NOP,               4'd1); // BOOT ignores redirect, counts it
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0000_0004, 1, 32'h0000_0000, mem(32'h0),        4'd1);
        vecs[2]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0000_0008, 1, 32'h0000_0004, mem(32'h4),        4'd1);
        vecs[3]  = mk(1, 0, 0, 0, 32'h0000_0300, 0, 32'h0000_000C, 1, 32'h0000_0008, mem(32'h8),        4'd1); // not taken
        vecs[4]  = mk(0, 1, 1, 0, 32'h0000_0300, 0, 32'h0000_0010, 1, 32'h0000_000C, mem(32'hC),        4'd1); // ex_valid low
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0000_0014, 1, 32'h0000_0010, mem(32'h10),       4'd1);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0000_0018, 1, 32'h0000_0014, mem(32'h14),       4'd1);
        vecs[7]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0000_001C, 1, 32'h0000_0018, mem(32'h18),       4'd1);
        vecs[8]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0000_0020, 1, 32'h0000_001C, mem(32'h1C),       4'd1);
        vecs[9]  = mk(1, 1, 0, 0, 32'h0000_0103, 1, 32'h0000_0100, 0, 32'h0000_0020, NOP,               4'd2); // taken, misaligned target
        vecs[10] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0000_0104, 1, 32'h0000_0100, mem(32'h100),      4'd2);
        vecs[11] = mk(1, 0, 1, 0, 32'h0000_003C, 1, 32'h0000_003C, 0, 32'h0000_0104, NOP,               4'd3); // jump
        vecs[12] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0000_0040, 1, 32'h0000_003C, mem(32'h3C),       4'd3);
        vecs[13] = mk(0, 0, 0, 1, 32'h0,         0, 32'h0000_0040, 1, 32'h0000_003C, mem(32'h3C),       4'd3); // stall holds
        vecs[14] = mk(1, 0, 1, 1, 32'h0000_0201, 1, 32'h0000_0200, 0, 32'h0000_0040, NOP,               4'd4); // jump beats stall
        vecs[15] = mk(0, 0, 0, 1, 32'h0,         0, 32'h0000_0200, 0, 32'h0000_0040, NOP,               4'd4); // stall holds bubble
        vecs[16] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0000_0204, 1, 32'h0000_0200, mem(32'h200),      4'd4);
        vecs[17] = mk(1, 1, 0, 0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC, 0, 32'h0000_0204, NOP,               4'd5);
        vecs[18] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0000_0000, 1, 32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 4'd5); // wrap
        vecs[19] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0000_0004, 1, 32'h0000_0000, mem(32'h0),        4'd5);

        drive(0, 0, 0, 0, 32'h0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst.imem_addr", imem_addr, 32'h0);
        chk("rst.if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst.if_pc", if_pc, 32'h0);
        chk("rst.if_instr", if_instr, NOP);
        chk("rst.cnt", {28'b0, redirect_cnt}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) step(vecs[i], i);

        // Twenty back-to-back jumps: counter climbs from 5 and pins at 4'hF.
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 1, 0, 32'h0000_1000 + 32'(i * 16) + 32'd2);
            @(posedge clk);
            #1;
            if (i == 9) chk("sat.cnt_at_10", {28'b0, redirect_cnt}, 32'hF);
        end
        chk("sat.cnt_at_20", {28'b0, redirect_cnt}, 32'hF);
        chk("sat.pc", imem_addr, 32'h0000_1130);
        chk("sat.if_valid", {31'b0, if_valid}, 32'h0);

        // Asynchronous reset between edges while a redirect is pending.
        drive(1, 1, 0, 0, 32'h0000_0080);
        #2;
        chk("arst.flush_pre", {31'b0, flush}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst.imem_addr", imem_addr, 32'h0);
        chk("arst.if_valid", {31'b0, if_valid}, 32'h0);
        chk("arst.if_pc", if_pc, 32'h0);
        chk("arst.if_instr", if_instr, NOP);
        chk("arst.cnt", {28'b0, redirect_cnt}, 32'h0);
        chk("arst.flush", {31'b0, flush}, 32'h1);
        drive(0, 0, 0, 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("boot2.pc", imem_addr, 32'h0);
        chk("boot2.if_valid", {31'b0, if_valid}, 32'h0);
        @(posedge clk);
        #1;
        chk("run2.pc", imem_addr, 32'h4);
        chk("run2.if_valid", {31'b0, if_valid}, 32'h1);
        chk("run2.if_pc", if_pc, 32'h0);
        chk("run2.if_instr", if_instr, mem(32'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Fetch-side PC and IF/ID pipeline-register controller for the 32-bit RV32I core.
- Consumes the branch comparator's br_taken result and the EX-stage target, then redirects the PC.
- On a redirect it kills the wrong-path instruction in IF and asserts a flush to squash the instruction in ID.
- Otherwise it advances the PC sequentially, honouring hazard stalls, and counts redirects for performance monitoring.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted into IF/ID on a kill.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- ex_valid  in  1  EX stage holds a valid instruction.
- br_taken  in  1  branch comparator result for the EX instruction.
- is_jump  in  1  EX instruction is JAL/JALR (unconditional).
- ex_target  in  32  branch/jump target computed in EX.
- stall  in  1  hazard-unit stall request for IF and ID.
- imem_addr  out  32  instruction memory address (combinational, equals pc).
- imem_rdata  in  32  instruction word; combinational read of imem_addr.
- if_pc  out  32  IF/ID register: PC of the ID instruction.
- if_instr  out  32  IF/ID register: instruction word.
- if_valid  out  1  IF/ID register: instruction valid.
- flush  out  1  combinational; squash ID/EX on the next edge.
- redirect_cnt  out  CNT_W  saturating count of redirects.

Behaviour:
- redirect = ex_valid & (br_taken | is_jump), combinational. flush = redirect.
- Target alignment: the next PC on a redirect is {ex_target[31:2], 2'b00}. Bits [1:0] are always dropped, with no trap.
- FSM states:
  - BOOT: entered on reset.
    - if_valid stays 0. pc holds RESET_PC.
    - Next edge goes to RUN with no pc update; the first real fetch occurs in RUN.
    - A redirect or stall seen while in BOOT is ignored.
  - RUN: steady operation. There is no other state.
- PC update in RUN, priority order (highest first):
  1. redirect: pc <= aligned target.
  2. stall: pc holds.
  3. otherwise: pc <= pc + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- IF/ID register in RUN, same priority order:
  1. redirect: if_valid <= 0, if_instr <= NOP_INSTR, if_pc <= pc. This kills the wrong-path fetch.
  2. stall: all three fields hold.
  3. otherwise: if_valid <= 1, if_instr <= imem_rdata, if_pc <= pc.
- Redirect during stall: redirect wins. The stall is ignored for that cycle and flush is still asserted.
- Fetch latency: an instruction fetched at pc in cycle n appears on if_* after edge n+1.
- Redirect penalty: after a redirect edge, the next valid if_* entry is the target instruction, one edge later (2-cycle bubble total, counting ID squashed via flush).
- redirect_cnt: increments by 1 on every clock edge where redirect=1, in both BOOT and RUN. Saturates at all-ones and never wraps.
- Reset values (asynchronous, on rst_n low at any time, including mid-stall or mid-redirect):
  - state=BOOT, pc=RESET_PC.
  - if_pc=0, if_instr=NOP_INSTR, if_valid=0.
  - redirect_cnt=0.
  - flush then follows its inputs combinationally.
- Outputs are registered except imem_addr and flush.
- No X propagation: if ex_valid=0, br_taken and is_jump are don't-care.

Test Plan:
- Reset release with RESET_PC=0 and imem_rdata=addr-based pattern, no stall -> if_valid=0 for the first edge (BOOT). Afterwards imem_addr steps 0,4,8,... and if_pc/if_instr track it with 1-cycle latency.
- Taken branch: ex_valid=1, br_taken=1, ex_target=32'h0000_0103 while pc=0x20 -> flush=1 that cycle. Next cycle: pc=0x100, if_valid=0, if_instr=0x13. Then if_pc=0x100 valid. redirect_cnt=1.
- Not-taken branch with ex_valid=1, br_taken=0, is_jump=0 -> flush=0, pc=pc+4, counter unchanged. Also ex_valid=0 with br_taken=1 -> no redirect.
- stall held 3 cycles at pc=0x40 -> imem_addr stays 0x40 and if_* hold. Adding a jump to 0x200 in the second stall cycle -> redirect wins: pc=0x200, if_valid=0.
- Wrap and saturation:
  - Force pc to 0xFFFF_FFFC -> next pc=0.
  - With CNT_W=4, apply 20 redirects -> redirect_cnt stays 4'hF.
- Assert rst_n low asynchronously mid-redirect (between edges) -> all registered outputs immediately take their reset values. On release, BOOT re-executes.
